// File: rtl/gray_pkg.sv
// Purpose : shared Gray-code helpers for this counter and the downstream Gray-to-binary decoder.
// Latency : n/a (functions and constants only).
// Backpressure: n/a.
//
// Contents:
//   GRAY_MAX_W - widest counter these helpers support; callers zero-extend into it
//   bin2gray   - binary to Gray, bin ^ (bin >> 1)
//   gray2bin   - Gray to binary, prefix XOR running down from the MSB
package gray_pkg;

   localparam int GRAY_MAX_W = 32;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
      logic [GRAY_MAX_W-1:0] bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_enc.sv
// Purpose : combinational binary-to-Gray encoder, WIDTH bits.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   i_bin  [WIDTH-1:0]  binary input
//   o_gray [WIDTH-1:0]  Gray-coded output
module gray_enc
#(
   parameter int WIDTH = 3
)
(
   input  logic [WIDTH-1:0] i_bin,
   output logic [WIDTH-1:0] o_gray
);

   assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// Purpose : up/down counter with registered Gray and binary outputs, load, terminal count and wrap flags.
// Latency : 1 cycle from en/load sampled to new gray_cnt/bin_cnt; tc is combinational.
// Backpressure: none; one step is taken on every enabled edge.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   en, up             count enable and direction (1 = increment)
//   load, load_val     synchronous load strobe and binary value (load beats en)
//   gray_cnt, bin_cnt  registered count, Gray and binary, always updated together
//   tc                 terminal count for the current direction (max when up, 0 when down)
//   wrap               one-cycle pulse after a step that crossed max<->0
//   chg                one-cycle pulse after an edge that changed gray_cnt
//
// Build option: define GRAY_CNT_SAT_EN to make the counter saturate at the terminal
// count instead of wrapping (load still works as usual).
module gray_code_counter
   import gray_pkg::*;
#(
   parameter int          WIDTH   = 3,
   parameter int unsigned RST_VAL = 0
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] gray_cnt,
   output logic [WIDTH-1:0] bin_cnt,
   output logic             tc,
   output logic             wrap,
   output logic             chg
);

   localparam logic [GRAY_MAX_W-1:0] RST_BIN_EXT  = GRAY_MAX_W'(RST_VAL);
   localparam logic [GRAY_MAX_W-1:0] RST_GRAY_EXT = bin2gray(RST_BIN_EXT);
   localparam logic [WIDTH-1:0]      RST_BIN      = RST_BIN_EXT[WIDTH-1:0];
   localparam logic [WIDTH-1:0]      RST_GRAY     = RST_GRAY_EXT[WIDTH-1:0];

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_wrap;
   logic             r_chg;

   logic [WIDTH-1:0] w_bin_step;
   logic [WIDTH-1:0] w_bin_nxt;
   logic [WIDTH-1:0] w_gray_nxt;
   logic             w_tc;
   logic             w_wrap_nxt;
   logic             w_chg_nxt;

   assign w_tc       = up ? (r_bin == {WIDTH{1'b1}}) : (r_bin == {WIDTH{1'b0}});
   // Natural overflow of the WIDTH-bit add/subtract gives the modulo wrap.
   assign w_bin_step = up ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));

   always_comb begin
      w_bin_nxt  = r_bin;
      w_chg_nxt  = 1'b0;
      w_wrap_nxt = 1'b0;
      if (load) begin
         w_bin_nxt = load_val;
         w_chg_nxt = (load_val != r_bin);
      end else if (en) begin
`ifdef GRAY_CNT_SAT_EN
         // Parked at the end for this direction: hold, report no change.
         if (!w_tc) begin
            w_bin_nxt = w_bin_step;
            w_chg_nxt = 1'b1;
         end
`else
         w_bin_nxt  = w_bin_step;
         w_chg_nxt  = 1'b1;
         w_wrap_nxt = w_tc;
`endif
      end
   end

   // Encode the next-state binary so the Gray output is a plain register,
   // never skewed from bin_cnt and free of decode glitches downstream.
   gray_enc #(.WIDTH(WIDTH)) u_gray_enc (
      .i_bin  (w_bin_nxt),
      .o_gray (w_gray_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin  <= RST_BIN;
         r_gray <= RST_GRAY;
         r_wrap <= 1'b0;
         r_chg  <= 1'b0;
      end else begin
         r_bin  <= w_bin_nxt;
         r_gray <= w_gray_nxt;
         r_wrap <= w_wrap_nxt;
         r_chg  <= w_chg_nxt;
      end
   end

   assign bin_cnt  = r_bin;
   assign gray_cnt = r_gray;
   assign wrap     = r_wrap;
   assign chg      = r_chg;
   assign tc       = w_tc;

endmodule

// File: tb/tb_gray_code_counter.sv
// Purpose : self-checking bench for gray_code_counter (WIDTH=3, RST_VAL=0).
// Latency : n/a.
// Backpressure: n/a.
//
// A counting model tracks the expected integer count, wrap and chg; a per-cycle
// compare process checks every output against it, and directed steps pin literal
// Gray/binary values. Expectations follow GRAY_CNT_SAT_EN when it is defined.
module tb_gray_code_counter;

   localparam int W    = 3;
   localparam int MOD  = 1 << W;
   localparam int MAXV = MOD - 1;
`ifdef GRAY_CNT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         en;
   logic         up;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] gray_cnt;
   logic [W-1:0] bin_cnt;
   logic         tc;
   logic         wrap;
   logic         chg;

   gray_code_counter #(.WIDTH(W), .RST_VAL(0)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .gray_cnt (gray_cnt),
      .bin_cnt  (bin_cnt),
      .tc       (tc),
      .wrap     (wrap),
      .chg      (chg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int to_gray(input int b);
      return b ^ (b >> 1);
   endfunction

   // Independent Gray decode: running parity of the bits from the MSB down.
   function automatic int from_gray(input int g);
      int acc = 0;
      int r   = 0;
      for (int i = W - 1; i >= 0; i--) begin
         acc = acc ^ ((g >> i) & 1);
         r   = r | (acc << i);
      end
      return r;
   endfunction

   function automatic int popcnt(input int v);
      int c = 0;
      for (int i = 0; i < W; i++) c += (v >> i) & 1;
      return c;
   endfunction

   // ---------------- model ----------------
   int m_cnt  = 0;
   bit m_wrap = 0;
   bit m_chg  = 0;
   bit m_step = 0;
   bit m_vld  = 0;

   always @(posedge clk) begin
      bit at_end;
      m_step = 0;
      if (rst) begin
         m_cnt = 0; m_wrap = 0; m_chg = 0; m_vld = 1;
      end else if (m_vld) begin
         if (load) begin
            m_chg  = (int'(load_val) != m_cnt);
            m_cnt  = int'(load_val);
            m_wrap = 0;
         end else if (en) begin
            at_end = up ? (m_cnt == MAXV) : (m_cnt == 0);
            if (at_end && SAT) begin
               m_chg = 0; m_wrap = 0;
            end else begin
               m_cnt  = up ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
               m_chg  = 1;
               m_wrap = at_end;
               m_step = 1;
            end
         end else begin
            m_chg = 0; m_wrap = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      int prev_gray = 0;
      forever begin
         @(negedge clk);
         if (m_vld) begin
            chk("gray", int'(gray_cnt), to_gray(m_cnt));
            chk("bin", int'(bin_cnt), m_cnt);
            chk("decode", from_gray(int'(gray_cnt)), m_cnt);
            chk("tc", int'(tc), int'((up && m_cnt == MAXV) || (!up && m_cnt == 0)));
            chk("wrap", int'(wrap), int'(m_wrap));
            chk("chg", int'(chg), int'(m_chg));
            if (m_step) chk("one_bit_step", popcnt(int'(gray_cnt) ^ prev_gray), 1);
         end
         prev_gray = int'(gray_cnt);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input bit r, input bit e, input bit u, input bit l, input int lv);
      rst = r; en = e; up = u; load = l; load_val = W'(lv);
      @(posedge clk);
      #1;
   endtask

`ifdef GRAY_CNT_SAT_EN
   int t1_gray[8] = '{1, 3, 2, 6, 7, 5, 4, 4};
   int t1_wrap[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
   int t1_chg[8]  = '{1, 1, 1, 1, 1, 1, 1, 0};
   int t2_bin[3]  = '{6, 5, 4};
   int t2_wrap[3] = '{0, 0, 0};
`else
   int t1_gray[8] = '{1, 3, 2, 6, 7, 5, 4, 0};
   int t1_wrap[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
   int t1_chg[8]  = '{1, 1, 1, 1, 1, 1, 1, 1};
   int t2_bin[3]  = '{7, 6, 5};
   int t2_wrap[3] = '{1, 0, 0};
`endif

   initial begin
      rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;

      // 1. reset, then count up through a full cycle
      step(1, 0, 1, 0, 0);
      step(1, 0, 1, 0, 0);
      chk("rst_gray", int'(gray_cnt), 0);
      chk("rst_bin", int'(bin_cnt), 0);
      chk("rst_wrap", int'(wrap), 0);
      chk("rst_chg", int'(chg), 0);
      chk("rst_tc_up", int'(tc), 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 1, 0, 0);
         chk($sformatf("t1_gray[%0d]", i), int'(gray_cnt), t1_gray[i]);
         chk($sformatf("t1_wrap[%0d]", i), int'(wrap), t1_wrap[i]);
         chk($sformatf("t1_chg[%0d]", i), int'(chg), t1_chg[i]);
         if (i == 6) chk("t1_tc_at_7", int'(tc), 1);
      end

      // 2. count down three steps
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 0);
         chk($sformatf("t2_bin[%0d]", i), int'(bin_cnt), t2_bin[i]);
         chk($sformatf("t2_gray[%0d]", i), int'(gray_cnt), to_gray(t2_bin[i]));
         chk($sformatf("t2_wrap[%0d]", i), int'(wrap), t2_wrap[i]);
      end
      step(0, 1, 0, 0, 0);

      // 3. load beats en; then hold; then reload of the same value
      step(0, 1, 1, 1, 5);
      chk("t3_load_gray", int'(gray_cnt), 7);
      chk("t3_load_bin", int'(bin_cnt), 5);
      chk("t3_load_chg", int'(chg), 1);
      step(0, 0, 1, 0, 0);
      chk("t3_hold_gray", int'(gray_cnt), 7);
      chk("t3_hold_chg", int'(chg), 0);
      step(0, 0, 1, 1, 5);
      chk("t3_same_load_chg", int'(chg), 0);

      // 4. reset mid-count overrides load and en
      step(0, 0, 1, 1, 2);
      step(0, 1, 1, 0, 0);
      chk("t4_bin3", int'(bin_cnt), 3);
      chk("t4_gray3", int'(gray_cnt), 2);
      step(1, 1, 1, 1, 6);
      chk("t4_rst_gray", int'(gray_cnt), 0);
      chk("t4_rst_bin", int'(bin_cnt), 0);
      chk("t4_rst_wrap", int'(wrap), 0);
      chk("t4_rst_chg", int'(chg), 0);
      step(0, 0, 0, 0, 0);
      chk("t4_tc_down_at_0", int'(tc), 1);
      step(0, 1, 0, 0, 0);
`ifdef GRAY_CNT_SAT_EN
      chk("t4_down_sat_bin", int'(bin_cnt), 0);
      chk("t4_down_sat_chg", int'(chg), 0);
`else
      chk("t4_down_wrap_bin", int'(bin_cnt), 7);
      chk("t4_down_wrap_gray", int'(gray_cnt), 4);
      chk("t4_down_wrap", int'(wrap), 1);
`endif

`ifdef GRAY_CNT_SAT_EN
      // 6. saturate going up from 110
      step(0, 0, 1, 1, 6);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 1, 0, 0);
         chk($sformatf("t6_gray[%0d]", i), int'(gray_cnt), 4);
         chk($sformatf("t6_wrap[%0d]", i), int'(wrap), 0);
         chk($sformatf("t6_chg[%0d]", i), int'(chg), (i == 0) ? 1 : 0);
      end
`endif

      // 5. random en/up/load with occasional reset; the compare process checks each cycle
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(63) == 0, $urandom_range(3) != 0, 1'($urandom_range(1)),
              $urandom_range(7) == 0, int'($urandom_range(MAXV)));
      end

      step(0, 0, 1, 0, 0);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
